// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_subtractor_if : operand/result handshake bundle for serial_subtractor
// rev 1.0
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   DIFF;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, DIFF
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, DIFF
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_subtractor : DIFF = {0,A} - {0,B}, DIGIT bits per cycle, valid/ready
// rev 1.0
// ----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_subtractor_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   diff_q;

  logic [DIGIT:0]   w_sub;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Bit DIGIT of the (DIGIT+1)-bit difference is the borrow out of this digit.
  assign w_sub      = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, borrow_q};
  assign w_res_next = (res_q >> DIGIT)
                    | (WIDTH'(w_sub[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last     = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_BUSY;
      S_BUSY:  if (w_last)        state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.DIFF = diff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          res_q    <= w_res_next;
          borrow_q <= w_sub[DIGIT];
          cnt_q    <= cnt_q + CW'(1);
          if (w_last) begin
            diff_q <= {w_sub[DIGIT], w_res_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_subtractor : scoreboard bench, directed DIGIT=4 plus 1/8/32 sweeps
// rev 1.0
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

  typedef struct {
    logic [32:0] d;
    int          acc;
  } exp_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic rst_sw_n = 1'b0;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(32)) bus ();
  serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t        exp_q[$];
  logic        pv_q  = 1'b0;
  logic [32:0] cur_q = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (bus.out_valid && !pv_q) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL main_unexpected: got result %h, expected no result", bus.DIFF);
      end else begin
        e = exp_q.pop_front();
        cur_q <= e.d;
        chk("main_diff", {31'd0, bus.DIFF}, {31'd0, e.d});
        chk("main_latency", 64'(cyc - e.acc), 64'd8);
      end
    end else if (bus.out_valid) begin
      chk("main_hold", {31'd0, bus.DIFF}, {31'd0, cur_q});
    end
    pv_q <= bus.out_valid;
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] d, input bit push);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back('{d, cyc});
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int D  = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
    localparam int NN = 32 / D;

    serial_subtractor_if #(.WIDTH(32)) sif ();
    serial_subtractor #(.WIDTH(32), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_sw_n),
      .bus   (sif.slave)
    );

    exp_t        q[$];
    logic        pv   = 1'b0;
    logic [32:0] cur  = '0;
    bit          done = 1'b0;

    initial begin : stim
      logic [31:0] a, b;
      int t;
      sif.in_valid  = 1'b0;
      sif.A         = '0;
      sif.B         = '0;
      sif.out_ready = 1'b1;
      wait (rst_sw_n == 1'b1);
      for (int i = 0; i < 1000; i++) begin
        a = $urandom;
        b = (i % 8 == 0) ? a : $urandom;
        t = 0;
        @(negedge clk);
        while (!sif.in_ready && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk($sformatf("sweep%0d_ready", D), {63'd0, sif.in_ready}, 64'd1);
        if (!sif.in_ready) break;
        sif.in_valid = 1'b1;
        sif.A        = a;
        sif.B        = b;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        q.push_back('{{1'b0, a} - {1'b0, b}, cyc});
      end
      repeat (NN + 4) @(negedge clk);
      chk($sformatf("sweep%0d_drain", D), 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (sif.out_valid && !pv) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sweep%0d_unexpected: got result %h, expected no result", D, sif.DIFF);
        end else begin
          e = q.pop_front();
          cur <= e.d;
          chk($sformatf("sweep%0d_diff", D), {31'd0, sif.DIFF}, {31'd0, e.d});
          chk($sformatf("sweep%0d_latency", D), 64'(cyc - e.acc), 64'(NN));
        end
      end else if (sif.out_valid) begin
        chk($sformatf("sweep%0d_hold", D), {31'd0, sif.DIFF}, {31'd0, cur});
      end
      pv <= sif.out_valid;
    end
  end

  initial begin : main
    int t;
    int seen;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_diff", {31'd0, bus.DIFF}, 64'd0);
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;

    issue(32'd10, 32'd3, 33'h0_0000_0007, 1'b1);
    issue(32'd3, 32'd10, 33'h1_FFFF_FFF9, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_0000_0000, 1'b1);
    issue(32'h0000_0000, 32'h0000_0001, 33'h1_FFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 33'h0_FFFF_FFFF, 1'b1);
    issue(32'h1234_5678, 32'h0000_1111, 33'h0_1234_4567, 1'b1);
    issue(32'h8000_0000, 32'h8000_0001, 33'h1_FFFF_FFFF, 1'b1);

    // Backpressure: hold DONE for 5 cycles while junk is driven on the inputs.
    wait_idle();
    bus.out_ready = 1'b0;
    issue(32'd100, 32'd1, 33'h0_0000_0063, 1'b1);
    seen = 0;
    t    = 0;
    while (seen < 5 && t < 60) begin
      @(negedge clk);
      t++;
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      if (bus.out_valid) begin
        seen++;
        chk("bp_hold", {31'd0, bus.DIFF}, 64'h63);
      end
      bus.in_valid = t[0];
      bus.A        = $urandom;
      bus.B        = $urandom;
    end
    chk("bp_valid_seen", 64'(seen), 64'd5);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_release_out_valid", {63'd0, bus.out_valid}, 64'd0);
    repeat (12) @(negedge clk);
    chk("bp_no_second_op", {63'd0, bus.out_valid}, 64'd0);

    // Asynchronous reset four cycles into BUSY discards the operation.
    issue(32'd50, 32'd20, 33'd0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_diff", {31'd0, bus.DIFF}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_no_stale", {63'd0, bus.out_valid}, 64'd0);
    issue(32'd7, 32'd7, 33'd0, 1'b1);

    wait_idle();
    repeat (4) @(negedge clk);
    chk("main_drain", 64'(exp_q.size()), 64'd0);

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 80000) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_finished",
        {63'd0, g_sweep[0].done && g_sweep[1].done && g_sweep[2].done}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
